// File: rtl/clk_switch_sequencer.sv
// Glitch-safe cluster clock-source switch sequencer with an APB register front end.
// Gates the clock and holds reset, flips the mux, waits a settle time, ungates, then releases reset.
module clk_switch_sequencer #(
    parameter int unsigned GUARD_CYCLES = 8,
    parameter int unsigned SETTLE_RST   = 64,
    parameter bit          INIT_SEL     = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [11:0] apb_paddr_i,
    input  logic [31:0] apb_pwdata_i,
    input  logic        apb_pwrite_i,
    input  logic        apb_psel_i,
    input  logic        apb_penable_i,
    output logic [31:0] apb_prdata_o,
    output logic        apb_pready_o,
    output logic        apb_pslverr_o,
    output logic        clk_sel_o,
    output logic        cluster_clk_en_o,
    output logic        rstn_cluster_req_o,
    output logic        busy_o,
    output logic        irq_o
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 32;

    localparam logic [ADDR_W-1:0] ADDR_CTRL   = 12'h040;
    localparam logic [ADDR_W-1:0] ADDR_STATUS = 12'h044;
    localparam logic [ADDR_W-1:0] ADDR_SETTLE = 12'h048;

    localparam logic [CNT_W-1:0] GUARD_M1 = CNT_W'(GUARD_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GATE    = 3'd1,
        ST_SWITCH  = 3'd2,
        ST_UNGATE  = 3'd3,
        ST_RELEASE = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               clk_sel_q, clk_sel_d;
    logic               clk_en_q, clk_en_d;
    logic               rstn_req_q, rstn_req_d;
    logic               busy_q, busy_d;
    logic               irq_q, irq_d;

    logic               target_q, target_d;
    logic               seq_tgt_q, seq_tgt_d;
    logic               start_q, start_d;
    logic [CNT_W-1:0]   settle_q, settle_d;
    logic               done_q, done_d;

    logic               access_c, wr_c;
    logic               hit_ctrl_c, hit_status_c, hit_settle_c;
    logic               busy_int_c;
    logic               err_c;
    logic               ctrl_we_c, settle_we_c, status_w1c_c;
    logic [DATA_W-1:0]  prdata_c;
    logic               unused_c;

    // APB decode; a start request still waiting for the FSM counts as busy
    assign access_c     = apb_psel_i & apb_penable_i;
    assign wr_c         = access_c & apb_pwrite_i;
    assign hit_ctrl_c   = (apb_paddr_i == ADDR_CTRL);
    assign hit_status_c = (apb_paddr_i == ADDR_STATUS);
    assign hit_settle_c = (apb_paddr_i == ADDR_SETTLE);
    assign busy_int_c   = (state_q != ST_IDLE) | start_q;

    assign err_c = access_c & (~(hit_ctrl_c | hit_status_c | hit_settle_c)
                   | (apb_pwrite_i & hit_ctrl_c & apb_pwdata_i[1] & busy_int_c)
                   | (apb_pwrite_i & hit_settle_c & busy_int_c));

    assign ctrl_we_c    = wr_c & hit_ctrl_c & ~err_c;
    assign settle_we_c  = wr_c & hit_settle_c & ~err_c;
    assign status_w1c_c = wr_c & hit_status_c & apb_pwdata_i[2];
    assign unused_c     = ^apb_pwdata_i[31:16];

    always_comb begin
        prdata_c = '0;
        if (access_c) begin
            case (apb_paddr_i)
                ADDR_CTRL:   prdata_c = DATA_W'(target_q);
                ADDR_STATUS: prdata_c = DATA_W'({done_q, clk_sel_q, busy_q});
                ADDR_SETTLE: prdata_c = DATA_W'(settle_q);
                default:     prdata_c = '0;
            endcase
        end
    end

    assign apb_prdata_o  = prdata_c;
    assign apb_pslverr_o = err_c;
    assign apb_pready_o  = 1'b1;

    // Software-visible registers; completion set beats a same-cycle W1C
    always_comb begin
        target_d  = target_q;
        seq_tgt_d = seq_tgt_q;
        start_d   = 1'b0;
        settle_d  = settle_q;
        done_d    = done_q;
        if (ctrl_we_c) begin
            target_d = apb_pwdata_i[0];
            if (apb_pwdata_i[1]) begin
                start_d   = 1'b1;
                seq_tgt_d = apb_pwdata_i[0];
            end
        end
        if (settle_we_c) begin
            settle_d = apb_pwdata_i[CNT_W-1:0];
        end
        if (status_w1c_c) begin
            done_d = 1'b0;
        end
        if (irq_d) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            target_q  <= 1'b0;
            seq_tgt_q <= 1'b0;
            start_q   <= 1'b0;
            settle_q  <= CNT_W'(SETTLE_RST);
            done_q    <= 1'b0;
        end else begin
            target_q  <= target_d;
            seq_tgt_q <= seq_tgt_d;
            start_q   <= start_d;
            settle_q  <= settle_d;
            done_q    <= done_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start_q && (seq_tgt_q != clk_sel_q)) begin
                    state_d = ST_GATE;
                    cnt_d   = GUARD_M1;
                end
            end
            ST_GATE: begin
                if (cnt_q == '0) begin
                    state_d = ST_SWITCH;
                    cnt_d   = settle_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_SWITCH: begin
                if (cnt_q == '0) begin
                    state_d = ST_UNGATE;
                    cnt_d   = GUARD_M1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_UNGATE: begin
                if (cnt_q == '0) begin
                    state_d = ST_RELEASE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Output values per state; the mux only moves while the clock is gated
    always_comb begin
        clk_sel_d  = clk_sel_q;
        clk_en_d   = 1'b1;
        rstn_req_d = 1'b1;
        busy_d     = (state_q != ST_IDLE);
        irq_d      = 1'b0;
        case (state_q)
            ST_IDLE:    irq_d = start_q & (seq_tgt_q == clk_sel_q);
            ST_GATE: begin
                clk_en_d   = 1'b0;
                rstn_req_d = 1'b0;
            end
            ST_SWITCH: begin
                clk_en_d   = 1'b0;
                rstn_req_d = 1'b0;
                clk_sel_d  = seq_tgt_q;
            end
            ST_UNGATE:  rstn_req_d = 1'b0;
            ST_RELEASE: irq_d = 1'b1;
            default:    ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clk_sel_q  <= INIT_SEL;
            clk_en_q   <= 1'b1;
            rstn_req_q <= 1'b1;
            busy_q     <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            clk_sel_q  <= clk_sel_d;
            clk_en_q   <= clk_en_d;
            rstn_req_q <= rstn_req_d;
            busy_q     <= busy_d;
            irq_q      <= irq_d;
        end
    end

    assign clk_sel_o          = clk_sel_q;
    assign cluster_clk_en_o   = clk_en_q;
    assign rstn_cluster_req_o = rstn_req_q;
    assign busy_o             = busy_q;
    assign irq_o              = irq_q;

endmodule

// File: tb/tb_clk_switch_sequencer.sv
// Bench for clk_switch_sequencer: directed scenarios plus random APB traffic checked
// against a timeline model computed from edge offsets since the accepted start write.
module tb_clk_switch_sequencer;

    localparam int G  = 8;
    localparam int SR = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic        pwrite, psel, penable;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic        clk_sel, clk_en, rstn_req, busy, irq;

    clk_switch_sequencer #(.GUARD_CYCLES(G), .SETTLE_RST(SR), .INIT_SEL(1'b0)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .apb_paddr_i(paddr), .apb_pwdata_i(pwdata), .apb_pwrite_i(pwrite),
        .apb_psel_i(psel), .apb_penable_i(penable),
        .apb_prdata_o(prdata), .apb_pready_o(pready), .apb_pslverr_o(pslverr),
        .clk_sel_o(clk_sel), .cluster_clk_en_o(clk_en), .rstn_cluster_req_o(rstn_req),
        .busy_o(busy), .irq_o(irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int edges = 0;
    bit chk_en = 1'b0;
    int irq_edge = -1;

    // reference model state
    int   t0, kind, s_m, last_k, settle_m, clr_edge;
    logic old_sel, tgt_m, tgt_last, done_prev;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, edges);
        end
    endtask

    always @(posedge clk) edges <= edges + 1;

    // {clk_sel, clk_en, rstn_req, busy, irq} after edge e
    function automatic logic [4:0] exp_out(input int e);
        int k;
        logic [4:0] r;
        k = e - t0;
        r = {old_sel, 1'b1, 1'b1, 1'b0, 1'b0};
        if (kind == 2) begin
            r[0] = (k == 1);
        end else if (kind == 1) begin
            if (k >= G + 2) r[4] = tgt_m;
            r[3] = !(k >= 2 && k <= G + s_m + 2);
            r[2] = !(k >= 2 && k <= 2*G + s_m + 2);
            r[1] = (k >= 2 && k <= 2*G + s_m + 3);
            r[0] = (k == 2*G + s_m + 3);
        end
        return r;
    endfunction

    function automatic bit busy_at(input int e);
        return (kind != 0) && (e - t0 >= 1) && (e - t0 <= last_k);
    endfunction

    function automatic logic done_at(input int e);
        int s_edge;
        logic d;
        d = done_prev && !(clr_edge >= t0 && clr_edge <= e);
        s_edge = t0 + last_k;
        if (kind != 0 && s_edge <= e && !(clr_edge > s_edge && clr_edge <= e)) d = 1'b1;
        return d;
    endfunction

    task automatic model_reset();
        kind = 0; t0 = 0; s_m = 0; last_k = 0; settle_m = SR; clr_edge = -1;
        old_sel = 1'b0; tgt_m = 1'b0; tgt_last = 1'b0; done_prev = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check_val("outs", 32'({clk_sel, clk_en, rstn_req, busy, irq}), 32'(exp_out(edges)));
            if (!psel) check_val("prdata_idle", prdata, 32'h0);
            if (irq) irq_edge = edges;
        end
    end

    // one APB transfer, called and returning at posedge+1
    task automatic apb(input bit wr, input logic [11:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic err, output int e);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        rd = prdata; err = pslverr;
        @(posedge clk); #1;
        e = edges;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic do_acc(input bit wr, input logic [11:0] a, input logic [31:0] d, input string tag);
        logic [31:0] rd, exp_rd;
        logic err, exp_err, cur;
        int e;
        logic [4:0] o;
        apb(wr, a, d, rd, err, e);
        o = exp_out(e - 1);
        exp_err = !(a == 12'h040 || a == 12'h044 || a == 12'h048)
                  || (wr && a == 12'h040 && d[1] && busy_at(e))
                  || (wr && a == 12'h048 && busy_at(e));
        case (a)
            12'h040: exp_rd = 32'(tgt_last);
            12'h044: exp_rd = 32'({done_at(e - 1), o[4], o[1]});
            12'h048: exp_rd = 32'(settle_m[15:0]);
            default: exp_rd = 32'h0;
        endcase
        check_val({tag, "_err"}, 32'(err), 32'(exp_err));
        check_val({tag, "_rd"}, rd, exp_rd);
        if (wr && !exp_err) begin
            if (a == 12'h040) begin
                tgt_last = d[0];
                if (d[1]) begin
                    cur = o[4];
                    done_prev = done_at(e);
                    clr_edge = -1;
                    old_sel = cur; tgt_m = d[0]; t0 = e; s_m = settle_m;
                    kind = (d[0] != cur) ? 2'd1 : 2'd2;
                    last_k = (kind == 1) ? 2*G + s_m + 3 : 1;
                end
            end else if (a == 12'h048) begin
                settle_m = int'(d[15:0]);
            end else if (a == 12'h044 && d[2]) begin
                clr_edge = e;
            end
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || busy_at(edges + 1)) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("wait_idle", 32'(busy), 32'h0);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        logic [11:0] bad_addr [5];
        bad_addr = '{12'h000, 12'h03C, 12'h04C, 12'h100, 12'hFFF};
        rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        model_reset();

        // reset values
        @(negedge clk);
        check_val("rst_outs", 32'({clk_sel, clk_en, rstn_req, busy, irq}), 32'b01100);
        check_val("rst_pready", 32'(pready), 32'h1);
        check_val("rst_pslverr", 32'(pslverr), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk_en = 1'b1;
        idle(2);
        do_acc(1'b0, 12'h044, 0, "rd_status0");
        do_acc(1'b0, 12'h048, 0, "rd_settle0");
        do_acc(1'b0, 12'h040, 0, "rd_ctrl0");

        // full switch to ref_clk, busy rejections mid-sequence
        do_acc(1'b1, 12'h040, 32'h3, "start_a");
        idle(8);
        do_acc(1'b1, 12'h040, 32'h3, "busy_ctrl");
        do_acc(1'b1, 12'h048, 32'd5, "busy_settle");
        do_acc(1'b0, 12'h048, 0, "rd_settle_busy");
        do_acc(1'b0, 12'h044, 0, "rd_status_busy");
        wait_idle();
        check_val("lat_full", 32'(irq_edge - t0), 32'd83);
        do_acc(1'b0, 12'h044, 0, "rd_status_done");

        // same target: no gating, immediate completion
        do_acc(1'b1, 12'h044, 32'h4, "w1c_a");
        do_acc(1'b1, 12'h040, 32'h3, "start_same");
        wait_idle();
        check_val("lat_same", 32'(irq_edge - t0), 32'd1);
        do_acc(1'b0, 12'h044, 0, "rd_status_same");

        // zero settle back to sys_clk
        do_acc(1'b1, 12'h048, 32'd0, "wr_settle0");
        do_acc(1'b1, 12'h040, 32'h2, "start_b");
        wait_idle();
        check_val("lat_settle0", 32'(irq_edge - t0), 32'd19);
        do_acc(1'b1, 12'h044, 32'h4, "w1c_b");
        do_acc(1'b0, 12'h044, 0, "rd_status_clr");

        // async reset while in SWITCH
        do_acc(1'b1, 12'h048, 32'd20, "wr_settle20");
        do_acc(1'b1, 12'h040, 32'h3, "start_c");
        while (edges - t0 < G + 4) begin @(posedge clk); #1; end
        chk_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check_val("async_rst", 32'({clk_sel, clk_en, rstn_req, busy, irq}), 32'b01100);
        repeat (3) begin
            @(negedge clk);
            check_val("rst_hold", 32'({clk_sel, clk_en, rstn_req, busy, irq}), 32'b01100);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        chk_en = 1'b1;
        idle(2);
        do_acc(1'b0, 12'h048, 0, "rd_settle_rst");
        do_acc(1'b0, 12'h100, 0, "unmapped_rd");
        do_acc(1'b1, 12'h100, 32'hFFFF_FFFF, "unmapped_wr");

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            int r;
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2: do_acc(1'b1, 12'h040, 32'({($urandom_range(0, 3) != 0), 1'($urandom)}), "r_ctrl");
                3:       do_acc(1'b1, 12'h048, 32'($urandom_range(0, 12)), "r_settle");
                4:       do_acc(1'b1, 12'h044, 32'($urandom_range(0, 7)), "r_status");
                5: begin
                    logic [11:0] ra;
                    ra = 12'h040 + 12'(4 * $urandom_range(0, 2));
                    do_acc(1'b0, ra, 0, "r_read");
                end
                6:       do_acc(1'($urandom), bad_addr[$urandom_range(0, 4)], $urandom, "r_unmapped");
                default: idle($urandom_range(0, 40));
            endcase
        end
        wait_idle();
        do_acc(1'b0, 12'h044, 0, "rd_status_final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
